// File: rtl/fp16_pkg.sv
// Shared definitions for the half-precision ALU scheduler: op codes,
// ALU status codes, scheduler state encoding and common constants.
package fp16_pkg;

    // Operation codes carried on req*_op / alu_op
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    // ALU exception-check status codes carried on alu_st / rsp_st
    localparam logic [1:0] ST_ZERO = 2'b00;
    localparam logic [1:0] ST_OVF  = 2'b01;
    localparam logic [1:0] ST_UNF  = 2'b10;
    localparam logic [1:0] ST_NORM = 2'b11;

    // Scheduler FSM states
    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_ISSUE = 2'd1,
        STATE_WAIT  = 2'd2,
        STATE_RESP  = 2'd3
    } state_e;

    // Result returned for reserved ops and timeouts
    localparam logic [15:0] FP16_ZERO = 16'h0000;

    // Width of the WAIT-state cycle counter (covers TIMEOUT up to 1023)
    localparam int CNT_W = 10;

    // Reserved ops never reach the ALU
    function automatic logic is_rsvd(input logic [1:0] op);
        return op == OP_RSVD;
    endfunction

endpackage

// File: rtl/fp16_alu_sched_arb.sv
// Two-input round-robin arbiter. On a tie the requester that did not win
// the previous arbitration is granted. last_grant only moves when the
// owner enables an update, so a grant that is not consumed is not counted.
module rr_arb2 (
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic en,
    output logic gnt0,
    output logic gnt1
);

    logic last_grant;

    // Requester 0 wins alone, or on a tie when 1 was granted last
    assign gnt0 = req0 & (~req1 | last_grant);
    assign gnt1 = req1 & (~req0 | ~last_grant);

    // Remember which requester was served; reset favours requester 0 next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (en && (gnt0 || gnt1)) begin
            last_grant <= gnt1;
        end
    end

endmodule

// File: rtl/fp16_alu_sched.sv
// Scheduler in front of the shared fp16 ALU. Two requesters are arbitrated
// round-robin, one operation is in flight at a time, the result is returned
// tagged with the requester id, and sticky overflow/underflow flags are kept.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. req*_ready is combinational and only asserted in IDLE; once
// rsp_valid rises, all rsp_* hold until rsp_ready is seen with it.
module fp16_alu_sched
    import fp16_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        alu_start,
    output logic [1:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic        alu_done,
    input  logic [15:0] alu_result,
    input  logic [1:0]  alu_st,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [15:0] rsp_result,
    output logic [1:0]  rsp_st,
    output logic        rsp_err,
    input  logic        flag_clr,
    output logic        sticky_ovf,
    output logic        sticky_unf,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] S_IDLE  = STATE_IDLE;
    localparam logic [1:0] S_ISSUE = STATE_ISSUE;
    localparam logic [1:0] S_WAIT  = STATE_WAIT;
    localparam logic [1:0] S_RESP  = STATE_RESP;

    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             gnt0;
    logic             gnt1;
    logic             accept;
    logic [1:0]       sel_op;
    logic [15:0]      sel_a;
    logic [15:0]      sel_b;
    logic             sel_rsvd;
    logic             capture;
    logic             timed_out;
    logic             rsp_hs;

    assign dbg_state = state;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req0  (req0_valid),
        .req1  (req1_valid),
        .en    (accept),
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

    // A request is taken whenever IDLE sees any valid requester
    assign accept     = (state == S_IDLE) && (req0_valid || req1_valid);
    assign req0_ready = (state == S_IDLE) && gnt0;
    assign req1_ready = (state == S_IDLE) && gnt1;

    // Operand mux for the granted requester
    assign sel_op   = gnt1 ? req1_op : req0_op;
    assign sel_a    = gnt1 ? req1_a  : req0_a;
    assign sel_b    = gnt1 ? req1_b  : req0_b;
    assign sel_rsvd = is_rsvd(sel_op);

    // Done is only honoured in WAIT; it beats a timeout in the same cycle.
    // The counter reaches TIMEOUT on the cycle it would be incremented to it.
    assign capture   = (state == S_WAIT) && alu_done;
    assign timed_out = (state == S_WAIT) && !alu_done && ((cnt + 1'b1) == TMO_LIMIT);
    assign rsp_hs    = (state == S_RESP) && rsp_ready;

    // FSM: IDLE -> ISSUE -> WAIT -> RESP, reserved ops skip straight to RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (accept) state <= sel_rsvd ? S_RESP : S_ISSUE;
                S_ISSUE: state <= S_WAIT;
                S_WAIT:  if (capture || timed_out) state <= S_RESP;
                S_RESP:  if (rsp_hs) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Cycle counter for the WAIT watchdog, cleared while issuing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == S_ISSUE) begin
            cnt <= '0;
        end else if (state == S_WAIT) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Latch the winner's op and operands; start pulses for the ISSUE cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_start <= 1'b0;
            alu_op    <= OP_ADD;
            alu_a     <= FP16_ZERO;
            alu_b     <= FP16_ZERO;
        end else begin
            alu_start <= accept && !sel_rsvd;
            if (accept) begin
                alu_op <= sel_op;
                alu_a  <= sel_a;
                alu_b  <= sel_b;
            end
        end
    end

    // Response registers: filled on done, timeout or reserved op, held in RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= FP16_ZERO;
            rsp_st     <= ST_ZERO;
            rsp_err    <= 1'b0;
        end else begin
            if (accept) begin
                rsp_id <= gnt1;
                if (sel_rsvd) begin
                    rsp_valid  <= 1'b1;
                    rsp_result <= FP16_ZERO;
                    rsp_st     <= ST_ZERO;
                    rsp_err    <= 1'b1;
                end
            end else if (capture) begin
                rsp_valid  <= 1'b1;
                rsp_result <= alu_result;
                rsp_st     <= alu_st;
                rsp_err    <= 1'b0;
            end else if (timed_out) begin
                rsp_valid  <= 1'b1;
                rsp_result <= FP16_ZERO;
                rsp_st     <= ST_ZERO;
                rsp_err    <= 1'b1;
            end else if (rsp_hs) begin
                rsp_valid  <= 1'b0;
            end
        end
    end

    // Sticky exception flags: a capture in the same cycle as a clear wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf <= 1'b0;
            sticky_unf <= 1'b0;
        end else begin
            if (capture && alu_st == ST_OVF) sticky_ovf <= 1'b1;
            else if (flag_clr)               sticky_ovf <= 1'b0;
            if (capture && alu_st == ST_UNF) sticky_unf <= 1'b1;
            else if (flag_clr)               sticky_unf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp16_alu_sched.sv
// Directed bench for fp16_alu_sched: reset, tie alternation, single op
// latency, sticky flags, reserved op, timeout, backpressure and mid-op reset.
module tb_fp16_alu_sched;
    import fp16_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        alu_start;
    logic [1:0]  alu_op;
    logic [15:0] alu_a, alu_b;
    logic        alu_done;
    logic [15:0] alu_result;
    logic [1:0]  alu_st;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [15:0] rsp_result;
    logic [1:0]  rsp_st;
    logic        flag_clr;
    logic        sticky_ovf, sticky_unf;
    logic [1:0]  dbg_state;

    int tests_run = 0;
    int fails = 0;

    fp16_alu_sched #(.TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result), .alu_st(alu_st),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_st(rsp_st), .rsp_err(rsp_err),
        .flag_clr(flag_clr), .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    // Advance to 1ns after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    // Accept one request at cycle T, raise done at T+1+lat; returns at T+2+lat
    task automatic run_op(input logic id, input logic [1:0] op,
                          input logic [15:0] a, input logic [15:0] b,
                          input int lat, input logic [15:0] res,
                          input logic [1:0] st, input logic clr);
        if (id) begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (lat) step();
        alu_done = 1'b1; alu_result = res; alu_st = st; flag_clr = clr;
        step();
        alu_done = 1'b0; flag_clr = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) step();
        tests_run++;
        if ({alu_start, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_result, rsp_st,
             rsp_err, sticky_ovf, sticky_unf, dbg_state} !== 60'd0) begin
            $display("FAIL reset_outputs: got rsp_valid=%b alu_a=%h state=%0d expected all zero",
                     rsp_valid, alu_a, dbg_state);
            fails++;
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_tie_alternation();
        logic exp_g;
        req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 16'h1000; req0_b = 16'h0001;
        req1_valid = 1'b1; req1_op = OP_ADD; req1_a = 16'h2000; req1_b = 16'h0002;
        for (int i = 0; i < 4; i++) begin
            exp_g = i[0];
            #1;
            tests_run++;
            if ({req1_ready, req0_ready} !== (exp_g ? 2'b10 : 2'b01)) begin
                $display("FAIL tie_grant[%0d]: got ready=%b%b expected grant %0d",
                         i, req1_ready, req0_ready, exp_g);
                fails++;
            end
            step();
            tests_run++;
            if (alu_start !== 1'b1 || alu_a !== (exp_g ? 16'h2000 : 16'h1000)) begin
                $display("FAIL tie_issue[%0d]: got start=%b a=%h", i, alu_start, alu_a);
                fails++;
            end
            step();
            alu_done = 1'b1; alu_result = 16'h3C00; alu_st = ST_NORM;
            step();
            alu_done = 1'b0;
            tests_run++;
            if ({rsp_valid, rsp_id, rsp_err} !== {1'b1, exp_g, 1'b0}) begin
                $display("FAIL tie_rsp[%0d]: got valid=%b id=%b err=%b expected id %0d",
                         i, rsp_valid, rsp_id, rsp_err, exp_g);
                fails++;
            end
            handshake();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 16'h3C00; req0_b = 16'h3C00;
        #1;
        tests_run++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            $display("FAIL single_ready: got %b%b expected 01", req1_ready, req0_ready);
            fails++;
        end
        step();                                     // T+1
        req0_valid = 1'b0;
        tests_run++;
        if ({alu_start, alu_op, alu_a, alu_b} !== {1'b1, OP_ADD, 16'h3C00, 16'h3C00}) begin
            $display("FAIL single_issue: got start=%b op=%b a=%h b=%h",
                     alu_start, alu_op, alu_a, alu_b);
            fails++;
        end
        step();                                     // T+2
        tests_run++;
        if (alu_start !== 1'b0) begin
            $display("FAIL single_start_pulse: got %b expected 0", alu_start);
            fails++;
        end
        step();                                     // T+3
        step();                                     // T+4
        alu_done = 1'b1; alu_result = 16'h4000; alu_st = ST_NORM;
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            $display("FAIL single_early_rsp: got rsp_valid=%b expected 0", rsp_valid);
            fails++;
        end
        step();                                     // T+5
        alu_done = 1'b0;
        tests_run++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_st, rsp_result} !==
            {1'b1, 1'b0, 1'b0, ST_NORM, 16'h4000}) begin
            $display("FAIL single_rsp: got v=%b id=%b err=%b st=%b res=%h expected 1 0 0 11 4000",
                     rsp_valid, rsp_id, rsp_err, rsp_st, rsp_result);
            fails++;
        end
        handshake();
        tests_run++;
        if (rsp_valid !== 1'b0 || dbg_state !== 2'd0) begin
            $display("FAIL single_after_hs: got valid=%b state=%0d expected 0 0",
                     rsp_valid, dbg_state);
            fails++;
        end
    endtask

    task automatic test_sticky_flags();
        run_op(1'b0, OP_MUL, 16'h7000, 16'h7000, 2, 16'h7BFF, ST_OVF, 1'b0);
        tests_run++;
        if ({rsp_st, rsp_result, sticky_ovf, sticky_unf} !== {ST_OVF, 16'h7BFF, 1'b1, 1'b0}) begin
            $display("FAIL ovf_capture: got st=%b res=%h ovf=%b unf=%b expected 01 7bff 1 0",
                     rsp_st, rsp_result, sticky_ovf, sticky_unf);
            fails++;
        end
        handshake();
        run_op(1'b1, OP_ADD, 16'h7800, 16'h7800, 1, 16'h7BFF, ST_OVF, 1'b1);
        tests_run++;
        if (sticky_ovf !== 1'b1) begin
            $display("FAIL ovf_set_beats_clr: got %b expected 1", sticky_ovf);
            fails++;
        end
        handshake();
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        tests_run++;
        if (sticky_ovf !== 1'b0) begin
            $display("FAIL ovf_clear: got %b expected 0", sticky_ovf);
            fails++;
        end
        run_op(1'b0, OP_MUL, 16'h0001, 16'h0001, 1, 16'h0000, ST_UNF, 1'b0);
        tests_run++;
        if ({rsp_st, sticky_unf, sticky_ovf} !== {ST_UNF, 1'b1, 1'b0}) begin
            $display("FAIL unf_capture: got st=%b unf=%b ovf=%b expected 10 1 0",
                     rsp_st, sticky_unf, sticky_ovf);
            fails++;
        end
        handshake();
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        tests_run++;
        if (sticky_unf !== 1'b0) begin
            $display("FAIL unf_clear: got %b expected 0", sticky_unf);
            fails++;
        end
    endtask

    task automatic test_reserved();
        req1_valid = 1'b1; req1_op = OP_RSVD; req1_a = 16'h1234; req1_b = 16'h5678;
        #1;
        tests_run++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            $display("FAIL rsvd_ready: got %b%b expected 10", req1_ready, req0_ready);
            fails++;
        end
        step();                                     // T+1
        req1_valid = 1'b0;
        tests_run++;
        if ({alu_start, rsp_valid, rsp_id, rsp_err, rsp_st, rsp_result} !==
            {1'b0, 1'b1, 1'b1, 1'b1, ST_ZERO, 16'h0000}) begin
            $display("FAIL rsvd_rsp: got start=%b v=%b id=%b err=%b st=%b res=%h expected 0 1 1 1 00 0000",
                     alu_start, rsp_valid, rsp_id, rsp_err, rsp_st, rsp_result);
            fails++;
        end
        step();
        tests_run++;
        if (alu_start !== 1'b0 || rsp_valid !== 1'b1) begin
            $display("FAIL rsvd_hold: got start=%b valid=%b expected 0 1", alu_start, rsp_valid);
            fails++;
        end
        handshake();
    endtask

    task automatic test_timeout();
        req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 16'h4200; req0_b = 16'h4400;
        step();                                     // T+1
        req0_valid = 1'b0;
        repeat (8) step();                          // T+9
        tests_run++;
        if (rsp_valid !== 1'b0 || dbg_state !== 2'd2) begin
            $display("FAIL tmo_early: got valid=%b state=%0d expected 0 2", rsp_valid, dbg_state);
            fails++;
        end
        step();                                     // T+10
        tests_run++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_st, rsp_result} !==
            {1'b1, 1'b0, 1'b1, ST_ZERO, 16'h0000}) begin
            $display("FAIL tmo_rsp: got v=%b id=%b err=%b st=%b res=%h expected 1 0 1 00 0000",
                     rsp_valid, rsp_id, rsp_err, rsp_st, rsp_result);
            fails++;
        end
        handshake();
        // stray done in IDLE
        alu_done = 1'b1; alu_result = 16'h7BFF; alu_st = ST_OVF;
        step();
        alu_done = 1'b0;
        tests_run++;
        if ({rsp_valid, alu_start, sticky_ovf, dbg_state} !== 5'd0) begin
            $display("FAIL stray_done: got v=%b start=%b ovf=%b state=%0d expected all 0",
                     rsp_valid, alu_start, sticky_ovf, dbg_state);
            fails++;
        end
        // done on the timeout cycle wins
        req1_valid = 1'b1; req1_op = OP_SUB; req1_a = 16'h4600; req1_b = 16'h3C00;
        step();                                     // T+1
        req1_valid = 1'b0;
        repeat (8) step();                          // T+9
        alu_done = 1'b1; alu_result = 16'h5555; alu_st = ST_NORM;
        step();                                     // T+10
        alu_done = 1'b0;
        tests_run++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_st, rsp_result} !==
            {1'b1, 1'b1, 1'b0, ST_NORM, 16'h5555}) begin
            $display("FAIL tmo_done_wins: got v=%b id=%b err=%b st=%b res=%h expected 1 1 0 11 5555",
                     rsp_valid, rsp_id, rsp_err, rsp_st, rsp_result);
            fails++;
        end
        handshake();
    endtask

    task automatic test_backpressure_reset();
        run_op(1'b1, OP_SUB, 16'h4400, 16'h3C00, 2, 16'h7BFF, ST_OVF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if ({rsp_valid, rsp_id, rsp_err, rsp_st, rsp_result, alu_a} !==
                {1'b1, 1'b1, 1'b0, ST_OVF, 16'h7BFF, 16'h4400}) begin
                $display("FAIL bp_hold[%0d]: got v=%b id=%b err=%b st=%b res=%h a=%h",
                         i, rsp_valid, rsp_id, rsp_err, rsp_st, rsp_result, alu_a);
                fails++;
            end
            step();
        end
        handshake();
        req0_valid = 1'b1; req0_op = OP_MUL; req0_a = 16'h4800; req0_b = 16'h4A00;
        step();                                     // ISSUE
        req0_valid = 1'b0;
        step();                                     // WAIT
        tests_run++;
        if (dbg_state !== 2'd2) begin
            $display("FAIL rst_pre_wait: got state=%0d expected 2", dbg_state);
            fails++;
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({alu_start, alu_op, alu_a, alu_b, rsp_valid, rsp_id, rsp_result, rsp_st,
             rsp_err, sticky_ovf, sticky_unf, dbg_state} !== 60'd0) begin
            $display("FAIL rst_midop: got a=%h ovf=%b state=%0d expected all zero",
                     alu_a, sticky_ovf, dbg_state);
            fails++;
        end
        step();
        rst_n = 1'b1;
        // late done after reset
        alu_done = 1'b1; alu_result = 16'h1111; alu_st = ST_UNF;
        step();
        alu_done = 1'b0;
        tests_run++;
        if ({rsp_valid, sticky_unf, dbg_state} !== 4'd0) begin
            $display("FAIL rst_late_done: got v=%b unf=%b state=%0d expected 0 0 0",
                     rsp_valid, sticky_unf, dbg_state);
            fails++;
        end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        tests_run++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            $display("FAIL rst_first_tie: got %b%b expected 01", req1_ready, req0_ready);
            fails++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_op = OP_ADD; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_op = OP_ADD; req1_a = '0; req1_b = '0;
        alu_done = 1'b0; alu_result = '0; alu_st = ST_ZERO;
        rsp_ready = 1'b0; flag_clr = 1'b0;

        test_reset();
        test_tie_alternation();
        test_single();
        test_sticky_flags();
        test_reserved();
        test_timeout();
        test_backpressure_reset();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/fp16_alu_sched.md
# fp16_alu_sched

Two-requester scheduler for the shared 16-bit half-precision floating-point ALU. Requests are arbitrated round-robin. The winner's operands are issued to the ALU with a start pulse. The block waits for the ALU's done strobe, then returns the result and the exception-check status to the requester by tag. It accumulates sticky overflow/underflow flags and aborts an ALU that never finishes.

## Interface
- `TIMEOUT`, 64, max cycles waited in WAIT after `alu_start` before abort (legal range 2..1023).
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req0_valid` / `req1_valid`  in  1  request pending.
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle.
- `req0_op` / `req1_op`  in  2  op: 00 add, 01 sub, 10 mul, 11 reserved.
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  16  operands (sign, 5-bit exponent, 10-bit mantissa).
- `alu_start`  out  1  one-cycle issue pulse.
- `alu_op`  out  2  latched op.
- `alu_a`, `alu_b`  out  16  latched operands, stable from issue until response completes.
- `alu_done`  in  1  ALU result valid, one-cycle strobe.
- `alu_result`  in  16  ALU result.
- `alu_st`  in  2  ALU status: 00 zero, 01 overflow, 10 underflow, 11 normal.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts response.
- `rsp_id`  out  1  requester tag (0/1).
- `rsp_result`  out  16  result.
- `rsp_st`  out  2  status.
- `rsp_err`  out  1  reserved op or timeout.
- `flag_clr`  in  1  clear sticky flags.
- `sticky_ovf`, `sticky_unf`  out  1  any overflow/underflow since last clear.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - Arbitrate among the valid requesters.
  - If both are valid, grant the one not granted last. `last_grant` resets to 1, so requester 0 wins the first tie.
  - Assert the winner's `req_ready` combinationally, in IDLE only. The loser sees ready=0.
  - Latch op, operands and id. Update `last_grant`.
  - Next state is ISSUE, or RESP directly if op=11.
- **Reserved op (11):** no ALU issue. Response is `rsp_err`=1, `rsp_result`=16'h0000, `rsp_st`=00.
- **ISSUE:** `alu_start`=1 for exactly this cycle. Clear the timeout counter. Go to WAIT.
- **WAIT:** the counter increments each cycle.
  - On `alu_done`: capture `alu_result` and `alu_st`, set `rsp_err`=0, go to RESP.
  - Else, if the counter reaches `TIMEOUT`: `rsp_err`=1, result 16'h0000, st 00, go to RESP.
  - If `alu_done` arrives on the timeout cycle, done wins.
- **RESP:** hold `rsp_valid`=1 and all `rsp_*` stable until `rsp_ready`. On handshake, go to IDLE.
- **Stray strobes:** `alu_done` outside WAIT is ignored, with no state or flag change.
- **Sticky flags:**
  - `sticky_ovf` is set when a captured `alu_st`=01; `sticky_unf` when a captured `alu_st`=10.
  - Timeouts and reserved ops do not set flags.
  - `flag_clr` clears both flags. If a set and `flag_clr` fall in the same cycle, the set wins.
- **Reset values:** state IDLE, all outputs 0 (`alu_a`/`alu_b`/`alu_op` 0, `rsp_*` 0, sticky 0), `last_grant`=1, counter 0. Reset mid-operation drops the in-flight request without a response. A late `alu_done` afterwards is ignored per the IDLE rule.

## Timing
- Request accepted at cycle T (valid & ready).
- `alu_start` at T+1.
- ALU done at T+1+L (L≥1).
- `rsp_valid` at T+2+L, registered.
- Reserved op: `rsp_valid` at T+1.
- Timeout: `rsp_valid` at T+2+`TIMEOUT`.
- Next acceptance no earlier than the cycle after the response handshake. Throughput is one operation in flight.
- All outputs are registered except `req0_ready`/`req1_ready`.

## Structure
- Shared package `fp16_pkg`:
  - op codes (OP_ADD, OP_SUB, OP_MUL, OP_RSVD);
  - status codes (ST_ZERO, ST_OVF, ST_UNF, ST_NORM);
  - FSM state enum;
  - constant FP16_ZERO = 16'h0000.
- One natural sub-module, `rr_arb2`: a two-input round-robin arbiter with a `last_grant` register and an update enable. Everything else is inline.

## Test plan
- Single request: req0 add, a=16'h3C00, b=16'h3C00. ALU done after L=3 with 16'h4000, st 11. Required response: `rsp_valid` at T+5, id 0, result 16'h4000, st 11, err 0.
- Tie and alternation: both requesters valid every cycle for 4 operations. Grants go 0,1,0,1, and each `rsp_id` matches its grant order.
- Overflow then clear: ALU returns 16'h7BFF, st 01. `sticky_ovf`=1 after capture. Pulse `flag_clr` on the same cycle as a second overflow capture: the flag stays 1. A later `flag_clr` alone clears it.
- Reserved op: req1 op=11. No `alu_start`. Response at T+1 with id 1, err 1, result 16'h0000, st 00.
- Timeout: `TIMEOUT`=8 with the ALU never done. Response at T+10 with err 1. An `alu_done` injected afterward in IDLE changes nothing.
- Backpressure and reset: hold `rsp_ready`=0 for 5 cycles; `rsp_*` stays stable. Assert `rst_n`=0 in WAIT: all outputs go 0 immediately, and after release req0 wins the first tie.
